glitch_pulse_sequencer: RTL and testbench

//  Programmable glitch-pulse sequencer for the glitch-injection datapath. Once armed with a config

---
 rtl/glitch_pulse_sequencer_pkg.sv | 17 +
 rtl/glitch_pulse_sequencer_if.sv | 28 ++
 rtl/glitch_pulse_sequencer_counter.sv | 32 +++
 rtl/glitch_pulse_sequencer.sv | 159 +++++++++++++++
 tb/tb_glitch_pulse_sequencer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/glitch_pulse_sequencer_pkg.sv
// Shared types and polarity helper for the glitch pulse sequencer.
package glitch_pulse_sequencer_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StArmed,
      StDelay,
      StPulse,
      StGap
   } state_t;

   // Drive level on the glitch enable for a given polarity and logical on/off.
   function automatic logic glitch_level(input bit active_low, input bit on);
      return on ^ active_low;
   endfunction

endpackage

// File: rtl/glitch_pulse_sequencer_if.sv
// Host-side configuration, control and status bundle of the glitch pulse sequencer.
interface glitch_pulse_sequencer_if #(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned NUM_W = 8
);
   logic [CNT_W-1:0] cfg_delay;
   logic [CNT_W-1:0] cfg_width;
   logic [CNT_W-1:0] cfg_gap;
   logic [NUM_W-1:0] cfg_count;
   logic             arm;
   logic             trigger;
   logic             abort;
   logic             glitch_o;
   logic             busy;
   logic             done;
   logic             cfg_err;
   logic [NUM_W-1:0] pulse_idx;

   modport master (
      output cfg_delay, cfg_width, cfg_gap, cfg_count, arm, trigger, abort,
      input  glitch_o, busy, done, cfg_err, pulse_idx
   );

   modport slave (
      input  cfg_delay, cfg_width, cfg_gap, cfg_count, arm, trigger, abort,
      output glitch_o, busy, done, cfg_err, pulse_idx
   );
endinterface

// File: rtl/glitch_pulse_sequencer_counter.sv
// Loadable down-counter that saturates at zero; shared by the delay, pulse and gap phases.
module glitch_pulse_sequencer_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] value_i,
   input  logic         dec_i,
   output logic         zero_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = value_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/glitch_pulse_sequencer.sv
// Programmable glitch-pulse sequencer: arm with a config snapshot, trigger, then emit
// COUNT pulses of WIDTH cycles after DELAY cycles, separated by GAP idle cycles.
module glitch_pulse_sequencer
   import glitch_pulse_sequencer_pkg::*;
#(
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned NUM_W      = 8,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input logic                     clk,
   input logic                     reset,
   glitch_pulse_sequencer_if.slave bus_io
);
   localparam logic             GlitchOn  = glitch_level(ACTIVE_LOW, 1'b1);
   localparam logic             GlitchOff = glitch_level(ACTIVE_LOW, 1'b0);
   localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
   localparam logic [NUM_W-1:0] NumOne    = NUM_W'(1);

   state_t           state_q;
   logic [CNT_W-1:0] delay_q, width_q, gap_q;
   logic [NUM_W-1:0] count_q, idx_q;
   logic             glitch_q, busy_q, done_q, cfg_err_q;

   logic             ctr_load, ctr_dec, ctr_zero;
   logic [CNT_W-1:0] ctr_value;
   logic             last_pulse;
   logic             cfg_bad;

   assign last_pulse = (idx_q == (count_q - NumOne));
   assign cfg_bad    = (bus_io.cfg_width == '0) || (bus_io.cfg_count == '0);

   // DELAY is entered on the trigger edge, so it spans delay_q+1 cycles ending at the pulse edge.
   always_comb begin
      ctr_load  = 1'b0;
      ctr_value = '0;
      ctr_dec   = 1'b0;
      if (bus_io.abort) begin
         ctr_load = 1'b1;
      end else begin
         unique case (state_q)
            StArmed: begin
               if (bus_io.trigger) begin
                  ctr_load  = 1'b1;
                  ctr_value = delay_q;
               end
            end
            StDelay, StGap: begin
               if (ctr_zero) begin
                  ctr_load  = 1'b1;
                  ctr_value = width_q - CntOne;
               end else begin
                  ctr_dec = 1'b1;
               end
            end
            StPulse: begin
               if (ctr_zero) begin
                  ctr_load  = !last_pulse;
                  ctr_value = gap_q - CntOne;
               end else begin
                  ctr_dec = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   glitch_pulse_sequencer_counter #(
      .W (CNT_W)
   ) u_counter (
      .clk     (clk),
      .reset   (reset),
      .load_i  (ctr_load),
      .value_i (ctr_value),
      .dec_i   (ctr_dec),
      .zero_o  (ctr_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         delay_q   <= '0;
         width_q   <= '0;
         gap_q     <= '0;
         count_q   <= '0;
         idx_q     <= '0;
         glitch_q  <= GlitchOff;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         if (bus_io.abort) begin
            state_q  <= StIdle;
            glitch_q <= GlitchOff;
            busy_q   <= 1'b0;
            idx_q    <= '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (bus_io.arm) begin
                     if (cfg_bad) begin
                        cfg_err_q <= 1'b1;
                     end else begin
                        delay_q <= bus_io.cfg_delay;
                        width_q <= bus_io.cfg_width;
                        gap_q   <= (bus_io.cfg_gap == '0) ? CntOne : bus_io.cfg_gap;
                        count_q <= bus_io.cfg_count;
                        state_q <= StArmed;
                        busy_q  <= 1'b1;
                     end
                  end
               end
               StArmed: begin
                  if (bus_io.trigger) begin
                     state_q <= StDelay;
                  end
               end
               StDelay: begin
                  if (ctr_zero) begin
                     state_q  <= StPulse;
                     glitch_q <= GlitchOn;
                  end
               end
               StPulse: begin
                  if (ctr_zero) begin
                     glitch_q <= GlitchOff;
                     if (last_pulse) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                     end else begin
                        state_q <= StGap;
                     end
                  end
               end
               StGap: begin
                  if (ctr_zero) begin
                     state_q  <= StPulse;
                     glitch_q <= GlitchOn;
                     idx_q    <= idx_q + NumOne;
                  end
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign bus_io.glitch_o  = glitch_q;
   assign bus_io.busy      = busy_q;
   assign bus_io.done      = done_q;
   assign bus_io.cfg_err   = cfg_err_q;
   assign bus_io.pulse_idx = idx_q;
endmodule

// File: tb/tb_glitch_pulse_sequencer.sv
// Randomized bench for glitch_pulse_sequencer against a timing-formula reference model,
// plus a 16-bit active-high instance exercising a full-scale pulse width.
module tb_glitch_pulse_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic reset2 = 1'b1;
   always #5 clk = ~clk;

   glitch_pulse_sequencer_if #(.CNT_W(32), .NUM_W(8)) bus ();
   glitch_pulse_sequencer_if #(.CNT_W(16), .NUM_W(8)) bus2 ();

   glitch_pulse_sequencer #(.CNT_W(32), .NUM_W(8), .ACTIVE_LOW(1'b1)) u_dut (
      .clk    (clk),
      .reset  (reset),
      .bus_io (bus)
   );

   glitch_pulse_sequencer #(.CNT_W(16), .NUM_W(8), .ACTIVE_LOW(1'b0)) u_dut16 (
      .clk    (clk),
      .reset  (reset2),
      .bus_io (bus2)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: expected outputs derived from the pulse-train timing formula.
   int     m_phase = 0;  // 0 idle, 1 armed, 2 running
   longint m_t = 0, m_s = 0, m_d = 0, m_w = 0, m_g = 0, m_n = 0;
   logic   e_glitch = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
   longint e_idx = 0;

   always @(posedge clk) begin
      longint rel, per;
      m_t++;
      e_done = 1'b0;
      e_err  = 1'b0;
      if (reset || bus.abort) begin
         m_phase = 0;
      end else begin
         case (m_phase)
            0: if (bus.arm) begin
               if (bus.cfg_width == 0 || bus.cfg_count == 0) begin
                  e_err = 1'b1;
               end else begin
                  m_d = longint'(bus.cfg_delay);
                  m_w = longint'(bus.cfg_width);
                  m_g = (bus.cfg_gap == 0) ? 1 : longint'(bus.cfg_gap);
                  m_n = longint'(bus.cfg_count);
                  m_phase = 1;
               end
            end
            1: if (bus.trigger) begin
               m_s = m_t + 1 + m_d;
               m_phase = 2;
            end
            default: if (m_t - m_s == m_n * m_w + (m_n - 1) * m_g) begin
               e_done = 1'b1;
               m_phase = 0;
            end
         endcase
      end
      e_busy   = (m_phase != 0);
      e_glitch = 1'b1;
      e_idx    = 0;
      if (m_phase == 2 && m_t >= m_s) begin
         rel      = m_t - m_s;
         per      = m_w + m_g;
         e_idx    = rel / per;
         e_glitch = ((rel % per) < m_w) ? 1'b0 : 1'b1;
      end
   end

   task automatic tick();
      @(negedge clk);
      check_eq("glitch", longint'(bus.glitch_o), longint'(e_glitch));
      check_eq("busy", longint'(bus.busy), longint'(e_busy));
      check_eq("done", longint'(bus.done), longint'(e_done));
      check_eq("cfg_err", longint'(bus.cfg_err), longint'(e_err));
      check_eq("pulse_idx", longint'(bus.pulse_idx), e_idx);
   endtask

   task automatic cycle(input logic a, input logic t, input logic ab);
      bus.arm     = a;
      bus.trigger = t;
      bus.abort   = ab;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic arm_cfg(input int d, input int w, input int g, input int n, input logic t);
      bus.cfg_delay = 32'(d);
      bus.cfg_width = 32'(w);
      bus.cfg_gap   = 32'(g);
      bus.cfg_count = 8'(n);
      cycle(1'b1, t, 1'b0);
   endtask

   initial begin
      int   cnt;
      logic seen_done;
      bus.cfg_delay = '0; bus.cfg_width = '0; bus.cfg_gap = '0; bus.cfg_count = '0;
      bus.arm = 1'b0; bus.trigger = 1'b0; bus.abort = 1'b0;
      bus2.cfg_delay = '0; bus2.cfg_width = '0; bus2.cfg_gap = '0; bus2.cfg_count = '0;
      bus2.arm = 1'b0; bus2.trigger = 1'b0; bus2.abort = 1'b0;
      idle(3);
      reset = 1'b0;

      // Single pulse after a delay.
      arm_cfg(3, 2, 4, 1, 1'b0);
      idle(2);
      cycle(1'b0, 1'b1, 1'b0);
      idle(10);
      // Zero delay, zero gap treated as one.
      arm_cfg(0, 1, 0, 3, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      idle(10);
      // Rejected configurations, then triggers that must do nothing.
      arm_cfg(2, 0, 3, 2, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
      arm_cfg(2, 3, 3, 0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
      // Abort mid-pulse, then a fresh arm.
      arm_cfg(0, 100, 1, 2, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      idle(50);
      cycle(1'b0, 1'b0, 1'b1);
      idle(3);
      arm_cfg(1, 2, 1, 1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      idle(8);
      // Trigger held before arm; second arm while busy is ignored.
      cycle(1'b0, 1'b1, 1'b0);
      arm_cfg(2, 3, 2, 2, 1'b1);
      arm_cfg(0, 7, 0, 5, 1'b1);
      for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 1'b0);
      // Trigger and abort together while armed.
      arm_cfg(0, 2, 1, 1, 1'b0);
      cycle(1'b0, 1'b1, 1'b1);
      idle(4);

      // Randomized traffic; cfg_* churns every cycle to prove the snapshot holds.
      for (int i = 0; i < 3000; i++) begin
         bus.cfg_delay = 32'($urandom_range(0, 5));
         bus.cfg_width = 32'($urandom_range(0, 6));
         bus.cfg_gap   = 32'($urandom_range(0, 4));
         bus.cfg_count = 8'($urandom_range(0, 4));
         reset = (i == 1500);
         cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 59) == 0));
      end
      reset = 1'b0;
      idle(2);

      // Full-scale 16-bit width on the active-high instance.
      reset2 = 1'b0;
      idle(2);
      check_eq("w16_idle_glitch", longint'(bus2.glitch_o), 0);
      check_eq("w16_idle_busy", longint'(bus2.busy), 0);
      bus2.cfg_delay = 16'd0; bus2.cfg_width = 16'hFFFF; bus2.cfg_gap = 16'd0;
      bus2.cfg_count = 8'd1;
      bus2.arm = 1'b1;
      idle(1);
      bus2.arm = 1'b0;
      bus2.trigger = 1'b1;
      idle(1);
      bus2.trigger = 1'b0;
      cnt = 0;
      seen_done = 1'b0;
      for (int i = 0; i < 70000 && !seen_done; i++) begin
         idle(1);
         if (bus2.glitch_o) cnt++;
         if (bus2.done) seen_done = 1'b1;
      end
      check_eq("w16_done_seen", longint'(seen_done), 1);
      check_eq("w16_active_cycles", longint'(cnt), 65535);
      check_eq("w16_busy_after", longint'(bus2.busy), 0);

      // Reset mid-pulse drops the enable on the next edge.
      bus2.arm = 1'b1;
      idle(1);
      bus2.arm = 1'b0;
      bus2.trigger = 1'b1;
      idle(1);
      bus2.trigger = 1'b0;
      idle(1000);
      check_eq("w16_mid_glitch", longint'(bus2.glitch_o), 1);
      reset2 = 1'b1;
      idle(1);
      check_eq("w16_rst_glitch", longint'(bus2.glitch_o), 0);
      check_eq("w16_rst_busy", longint'(bus2.busy), 0);
      check_eq("w16_rst_done", longint'(bus2.done), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
